// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball physics: per-tick motion, wall/paddle bounces, hit score, serve/play/over FSM.
// Positions are top-left pixels; all motion arithmetic is carried in 10 bits so sums never wrap.
module ball_engine #(
  parameter int SCREEN_WIDTH  = 430,
  parameter int SCREEN_HEIGHT = 300,
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int PAD_WIDTH     = 40,
  parameter int PAD_HEIGHT    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [8:0] pad_xpos,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic       playing,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score
);

  localparam logic [9:0] SPD   = 10'(BALL_SPEED);
  localparam logic [9:0] BSZ   = 10'(BALL_SIZE);
  localparam logic [9:0] PAD_W = 10'(PAD_WIDTH);
  localparam logic [9:0] PAD_Y = 10'(SCREEN_HEIGHT - PAD_HEIGHT);
  localparam logic [9:0] X_MAX = 10'(SCREEN_WIDTH - BALL_SIZE);
  localparam logic [9:0] Y_MAX = 10'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [8:0] SX    = 9'((SCREEN_WIDTH - BALL_SIZE) / 2);
  localparam logic [8:0] SY    = 9'(SCREEN_HEIGHT / 2);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic       dx_right_q, dx_right_d;
  logic       dy_down_q, dy_down_d;
  logic [7:0] score_q, score_d;
  logic       hit_q, hit_d, miss_q, miss_d;

  logic [9:0] x10, y10, pad10, x_n10, y_n10;
  logic       pad_zone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= SX;
      y_q        <= SY;
      dx_right_q <= 1'b1;
      dy_down_q  <= 1'b0;
      score_q    <= 8'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_right_q <= dx_right_d;
      dy_down_q  <= dy_down_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dx_right_d = dx_right_q;
    dy_down_d  = dy_down_q;
    score_d    = score_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    x10        = {1'b0, x_q};
    y10        = {1'b0, y_q};
    pad10      = {1'b0, pad_xpos};
    x_n10      = x10;
    y_n10      = y10;
    // Ball's vertical sweep this tick crosses the paddle top while overlapping it horizontally.
    pad_zone   = (y10 + BSZ <= PAD_Y) && (y10 + SPD + BSZ >= PAD_Y) &&
                 (x10 + BSZ > pad10) && (x10 < pad10 + PAD_W);

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d    = PLAY;
          x_n10      = {1'b0, SX};
          y_n10      = {1'b0, SY};
          dx_right_d = 1'b1;
          dy_down_d  = 1'b0;
          score_d    = 8'd0;
        end
      end
      PLAY: begin
        if (tick) begin
          if (!dx_right_q) begin
            if (x10 <= SPD) begin
              x_n10      = 10'd0;
              dx_right_d = 1'b1;
            end else begin
              x_n10 = x10 - SPD;
            end
          end else if (x10 + SPD >= X_MAX) begin
            x_n10      = X_MAX;
            dx_right_d = 1'b0;
          end else begin
            x_n10 = x10 + SPD;
          end

          if (!dy_down_q) begin
            if (y10 <= SPD) begin
              y_n10     = 10'd0;
              dy_down_d = 1'b1;
            end else begin
              y_n10 = y10 - SPD;
            end
          end else if (pad_zone) begin
            y_n10     = PAD_Y - BSZ;
            dy_down_d = 1'b0;
            hit_d     = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else if (y10 + SPD >= Y_MAX) begin
            y_n10   = Y_MAX;
            miss_d  = 1'b1;
            state_d = OVER;
          end else begin
            y_n10 = y10 + SPD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    x_d = x_n10[8:0];
    y_d = y_n10[8:0];
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign playing = (state_q == PLAY);
  assign hit     = hit_q;
  assign miss    = miss_q;
  assign score   = score_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - Directed bench for ball_engine with hand-computed trajectory checkpoints.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       reset, tick, start;
  logic [8:0] pad_xpos;
  logic [8:0] ball_x, ball_y;
  logic       playing, hit, miss;
  logic [7:0] score;

  int  n_pass  = 0;
  int  n_total = 0;
  int  k       = 0;
  bit  track   = 1'b0;

  ball_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pad_xpos(pad_xpos),
    .ball_x(ball_x), .ball_y(ball_y), .playing(playing), .hit(hit), .miss(miss),
    .score(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One frame tick; with tracking on, the paddle sits under the ball so every descent is a hit.
  task automatic tick_once();
    tick = 1'b1;
    if (track) pad_xpos = ball_x;
    cycle();
    tick = 1'b0;
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick_once();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; pad_xpos = 9'd200;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_x", int'(ball_x), 211);
    check("rst_y", int'(ball_y), 150);
    check("rst_playing", int'(playing), 0);
    check("rst_score", int'(score), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_miss", int'(miss), 0);

    for (int i = 0; i < 5; i++) begin
      tick_once();
      check("idle_tick_hit", int'(hit), 0);
      check("idle_tick_miss", int'(miss), 0);
    end
    check("idle_x", int'(ball_x), 211);
    check("idle_y", int'(ball_y), 150);
    check("idle_playing", int'(playing), 0);

    start = 1'b1;
    cycle();
    start = 1'b0;
    k = 0;
    check("serve_playing", int'(playing), 1);
    check("serve_x", int'(ball_x), 211);
    check("serve_y", int'(ball_y), 150);

    tick_once();
    check("t1_x", int'(ball_x), 213);
    check("t1_y", int'(ball_y), 148);
    start = 1'b1;
    tick_once();
    start = 1'b0;
    check("play_start_ign_x", int'(ball_x), 215);
    check("play_start_ign_y", int'(ball_y), 146);

    track = 1'b1;
    tick_to(74);
    check("t74_y", int'(ball_y), 2);
    tick_to(75);
    check("top_bounce_y", int'(ball_y), 0);
    tick_to(76);
    check("after_top_y", int'(ball_y), 2);
    tick_to(105);
    check("t105_x", int'(ball_x), 421);
    tick_to(106);
    check("right_wall_x", int'(ball_x), 422);
    tick_to(107);
    check("after_right_x", int'(ball_x), 420);

    tick_to(210);
    check("pre_hit_y", int'(ball_y), 270);
    check("pre_hit_pulse", int'(hit), 0);
    tick_to(211);
    check("hit1_y", int'(ball_y), 272);
    check("hit1_x", int'(ball_x), 212);
    check("hit1_pulse", int'(hit), 1);
    check("hit1_score", int'(score), 1);
    tick_to(212);
    check("hit1_end", int'(hit), 0);
    check("hit1_up_y", int'(ball_y), 270);
    check("hit1_score_hold", int'(score), 1);

    tick_to(69298);
    check("score_254", int'(score), 254);
    tick_to(69299);
    check("hit255_pulse", int'(hit), 1);
    check("score_255", int'(score), 255);
    tick_to(69571);
    check("hit256_pulse", int'(hit), 1);
    check("hit256_y", int'(ball_y), 272);
    check("score_sat", int'(score), 255);

    reset = 1'b1; tick = 1'b1; start = 1'b1;
    cycle();
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    check("midrst_x", int'(ball_x), 211);
    check("midrst_y", int'(ball_y), 150);
    check("midrst_playing", int'(playing), 0);
    check("midrst_score", int'(score), 0);
    check("midrst_hit", int'(hit), 0);
    check("midrst_miss", int'(miss), 0);

    start = 1'b1; tick = 1'b1;
    cycle();
    start = 1'b0; tick = 1'b0;
    k = 0;
    check("serve_tick_x", int'(ball_x), 211);
    check("serve_tick_y", int'(ball_y), 150);
    check("serve_tick_playing", int'(playing), 1);

    track = 1'b0;
    pad_xpos = 9'd0;
    tick_to(220);
    check("pre_miss_x", int'(ball_x), 194);
    check("pre_miss_y", int'(ball_y), 290);
    check("pre_miss_pulse", int'(miss), 0);
    tick_to(221);
    check("miss_x", int'(ball_x), 192);
    check("miss_y", int'(ball_y), 292);
    check("miss_pulse", int'(miss), 1);
    check("miss_playing", int'(playing), 0);
    check("miss_score", int'(score), 0);
    cycle();
    check("miss_end", int'(miss), 0);
    for (int i = 0; i < 5; i++) tick_once();
    check("frozen_x", int'(ball_x), 192);
    check("frozen_y", int'(ball_y), 292);
    check("frozen_miss", int'(miss), 0);
    check("frozen_playing", int'(playing), 0);

    start = 1'b1;
    cycle();
    start = 1'b0;
    check("reserve_x", int'(ball_x), 211);
    check("reserve_y", int'(ball_y), 150);
    check("reserve_score", int'(score), 0);
    check("reserve_playing", int'(playing), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
